// File: rtl/fetch_sched.sv
// Multithreaded fetch stage: round-robin thread pick, synchronous imem read and a
// valid/ready output stage to decode, plus thread control, redirect and allocation.
module fetch_sched #(
  parameter int unsigned THREADS  = 8,
  parameter int unsigned TID_W    = $clog2(THREADS),
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [31:0]        imem_addr,
  input  logic [31:0]        imem_rdata,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_ins,
  output logic [TID_W-1:0]   out_tid,
  output logic [31:0]        out_pc,
  input  logic               redir_en,
  input  logic [TID_W-1:0]   redir_tid,
  input  logic [31:0]        redir_pc,
  input  logic [1:0]         tctl_op,
  input  logic [TID_W-1:0]   tctl_tid,
  input  logic               init_req,
  input  logic [31:0]        init_pc,
  output logic               init_ack,
  output logic               init_ok,
  output logic [TID_W-1:0]   init_tid,
  output logic [THREADS-1:0] active_mask
);

  typedef enum logic [1:0] {StIdle, StReady, StSleep} thread_st_e;

  localparam logic [1:0] OpSleep = 2'b01;
  localparam logic [1:0] OpWake  = 2'b10;
  localparam logic [1:0] OpKill  = 2'b11;

  thread_st_e       st_q [THREADS];
  logic [31:0]      pc_q [THREADS];
  logic [TID_W-1:0] rr_q;

  logic [THREADS-1:0] eligible;
  logic [THREADS-1:0] idle;
  logic               found;
  logic               idle_found;
  logic               stall;
  logic               issue;
  logic               squash;
  logic               op_kill;
  logic [TID_W-1:0]   sel;
  logic [TID_W-1:0]   idle_id;
  logic [TID_W-1:0]   next_tid;

  // A thread already sitting in the output stage may not issue again.
  always_comb begin
    eligible = '0;
    idle     = '0;
    for (int i = 0; i < THREADS; i++) begin
      eligible[i] = (st_q[i] == StReady) && !(out_valid && (out_tid == TID_W'(i)));
      idle[i]     = (st_q[i] == StIdle);
    end
  end

  assign active_mask = ~idle;

  always_comb begin
    found = 1'b0;
    sel   = rr_q;
    for (int k = 0; k < THREADS; k++) begin
      if (!found && eligible[rr_q + TID_W'(k)]) begin
        found = 1'b1;
        sel   = rr_q + TID_W'(k);
      end
    end
  end

  always_comb begin
    idle_found = 1'b0;
    idle_id    = '0;
    for (int i = THREADS - 1; i >= 0; i--) begin
      if (idle[i]) begin
        idle_found = 1'b1;
        idle_id    = TID_W'(i);
      end
    end
  end

  assign stall    = out_valid & ~out_ready;
  assign issue    = ~stall & found;
  assign next_tid = issue ? sel : out_tid;
  assign op_kill  = (tctl_op == OpKill);

  // Whatever would occupy the output stage next is dropped if its thread is being
  // redirected, put to sleep or killed this cycle.
  assign squash = (redir_en && (redir_tid == next_tid)) ||
                  (((tctl_op == OpSleep) || op_kill) && (tctl_tid == next_tid));

  assign imem_req  = issue & rst_n;
  assign imem_addr = pc_q[sel];
  assign out_ins   = imem_rdata;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < THREADS; i++) begin
        st_q[i] <= (i == 0) ? StReady : StIdle;
        pc_q[i] <= (i == 0) ? RESET_PC : 32'h0;
      end
      rr_q      <= '0;
      out_valid <= 1'b0;
      out_tid   <= '0;
      out_pc    <= '0;
      init_ack  <= 1'b0;
      init_ok   <= 1'b0;
      init_tid  <= '0;
    end else begin
      out_valid <= (issue || stall) && !squash;
      if (issue) begin
        rr_q    <= sel + TID_W'(1);
        out_tid <= sel;
        out_pc  <= pc_q[sel];
      end

      // Later assignments take priority: increment < redirect < kill < init.
      for (int i = 0; i < THREADS; i++) begin
        if (issue && (sel == TID_W'(i))) pc_q[i] <= pc_q[i] + 32'd4;
        if (redir_en && (redir_tid == TID_W'(i)) && (st_q[i] != StIdle)) pc_q[i] <= redir_pc;
        if (tctl_tid == TID_W'(i)) begin
          unique case (tctl_op)
            OpSleep: if (st_q[i] == StReady) st_q[i] <= StSleep;
            OpWake:  if (st_q[i] == StSleep) st_q[i] <= StReady;
            OpKill: begin
              st_q[i] <= StIdle;
              pc_q[i] <= pc_q[i];
            end
            default: ;
          endcase
        end
        if (init_req && idle_found && (idle_id == TID_W'(i))) begin
          st_q[i] <= StReady;
          pc_q[i] <= init_pc;
        end
      end

      init_ack <= init_req;
      init_ok  <= init_req && idle_found;
      init_tid <= (init_req && idle_found) ? idle_id : '0;
    end
  end

endmodule

// File: tb/tb_fetch_sched.sv
// Directed bench for fetch_sched: imem echoes the address as data, every expected
// PC, thread id and allocation result below is worked out by hand.
module tb_fetch_sched;

  localparam int unsigned THREADS = 8;
  localparam int unsigned TID_W   = 3;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               imem_req;
  logic [31:0]        imem_addr;
  logic [31:0]        imem_rdata;
  logic               out_valid;
  logic               out_ready;
  logic [31:0]        out_ins;
  logic [TID_W-1:0]   out_tid;
  logic [31:0]        out_pc;
  logic               redir_en;
  logic [TID_W-1:0]   redir_tid;
  logic [31:0]        redir_pc;
  logic [1:0]         tctl_op;
  logic [TID_W-1:0]   tctl_tid;
  logic               init_req;
  logic [31:0]        init_pc;
  logic               init_ack;
  logic               init_ok;
  logic [TID_W-1:0]   init_tid;
  logic [THREADS-1:0] active_mask;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Synchronous memory that returns the address as data and holds it when idle.
  always @(posedge clk) begin
    if (!rst_n) imem_rdata <= 32'h0;
    else if (imem_req) imem_rdata <= imem_addr;
  end

  fetch_sched #(
    .THREADS (THREADS),
    .TID_W   (TID_W),
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_ins    (out_ins),
    .out_tid    (out_tid),
    .out_pc     (out_pc),
    .redir_en   (redir_en),
    .redir_tid  (redir_tid),
    .redir_pc   (redir_pc),
    .tctl_op    (tctl_op),
    .tctl_tid   (tctl_tid),
    .init_req   (init_req),
    .init_pc    (init_pc),
    .init_ack   (init_ack),
    .init_ok    (init_ok),
    .init_tid   (init_tid),
    .active_mask(active_mask)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Combinational fetch request seen before the next edge.
  task automatic fetch_chk(input string tag, input logic req, input logic [31:0] addr);
    #1;
    check({tag, "_req"}, 32'(imem_req), 32'(req));
    if (req) check({tag, "_addr"}, imem_addr, addr);
  endtask

  task automatic out_chk(input string tag, input logic vld, input int tid, input logic [31:0] pc);
    check({tag, "_vld"}, 32'(out_valid), 32'(vld));
    if (vld) begin
      check({tag, "_tid"}, 32'(out_tid), 32'(tid));
      check({tag, "_pc"}, out_pc, pc);
      check({tag, "_ins"}, out_ins, pc);
    end
  endtask

  task automatic ack_chk(input string tag, input logic ok, input int tid);
    check({tag, "_ack"}, 32'(init_ack), 32'd1);
    check({tag, "_ok"}, 32'(init_ok), 32'(ok));
    check({tag, "_tid"}, 32'(init_tid), 32'(tid));
  endtask

  initial begin
    rst_n     = 1'b0;
    out_ready = 1'b1;
    redir_en  = 1'b0;
    redir_tid = '0;
    redir_pc  = '0;
    tctl_op   = 2'b00;
    tctl_tid  = '0;
    init_req  = 1'b0;
    init_pc   = '0;
    tick();
    tick();
    check("rst_imem_req", 32'(imem_req), 32'd0);
    rst_n = 1'b1;
    #1;
    out_chk("rst", 1'b0, 0, 32'h0);
    check("rst_tid", 32'(out_tid), 32'd0);
    check("rst_pc", out_pc, 32'h0);
    check("rst_ack", 32'(init_ack), 32'd0);
    check("rst_mask", 32'(active_mask), 32'h01);

    // Single thread issues every other cycle.
    fetch_chk("a", 1'b1, 32'h0);   tick(); out_chk("a", 1'b1, 0, 32'h0);
    fetch_chk("b", 1'b0, 32'h0);   tick(); out_chk("b", 1'b0, 0, 32'h0);
    fetch_chk("c", 1'b1, 32'h4);   tick(); out_chk("c", 1'b1, 0, 32'h4);
    fetch_chk("d", 1'b0, 32'h0);   tick(); out_chk("d", 1'b0, 0, 32'h0);
    init_req = 1'b1;
    init_pc  = 32'h100;
    fetch_chk("e", 1'b1, 32'h8);   tick(); out_chk("e", 1'b1, 0, 32'h8);
    ack_chk("init1", 1'b1, 1);
    check("init1_mask", 32'(active_mask), 32'h03);
    init_req = 1'b0;

    // Two threads interleave at one instruction per cycle.
    fetch_chk("f", 1'b1, 32'h100); tick(); out_chk("f", 1'b1, 1, 32'h100);
    check("f_ack", 32'(init_ack), 32'd0);
    fetch_chk("g", 1'b1, 32'hC);   tick(); out_chk("g", 1'b1, 0, 32'hC);
    fetch_chk("h", 1'b1, 32'h104); tick(); out_chk("h", 1'b1, 1, 32'h104);

    // Backpressure holds the output stage and blocks issue.
    out_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      fetch_chk("stall", 1'b0, 32'h0); tick(); out_chk("stall", 1'b1, 1, 32'h104);
    end
    out_ready = 1'b1;
    fetch_chk("l", 1'b1, 32'h10);  tick(); out_chk("l", 1'b1, 0, 32'h10);
    fetch_chk("m", 1'b1, 32'h108); tick(); out_chk("m", 1'b1, 1, 32'h108);

    // Redirect squashes the stalled tid1 instruction.
    out_ready = 1'b0;
    fetch_chk("n", 1'b0, 32'h0);   tick(); out_chk("n", 1'b1, 1, 32'h108);
    redir_en  = 1'b1;
    redir_tid = 3'd1;
    redir_pc  = 32'h200;
    fetch_chk("o", 1'b0, 32'h0);   tick(); out_chk("o_squash", 1'b0, 0, 32'h0);
    redir_en  = 1'b0;
    out_ready = 1'b1;
    fetch_chk("p", 1'b1, 32'h14);  tick(); out_chk("p", 1'b1, 0, 32'h14);
    fetch_chk("q", 1'b1, 32'h200); tick(); out_chk("q", 1'b1, 1, 32'h200);

    // Kill with a simultaneous redirect of tid1: kill wins.
    redir_en  = 1'b1;
    redir_pc  = 32'h300;
    tctl_op   = 2'b11;
    tctl_tid  = 3'd1;
    fetch_chk("r", 1'b1, 32'h18);  tick(); out_chk("r", 1'b1, 0, 32'h18);
    check("kill_mask", 32'(active_mask), 32'h01);
    redir_en = 1'b0;
    tctl_op  = 2'b00;
    for (int s = 0; s < 4; s++) begin
      tick();
      check("post_kill_tid", 32'(out_tid), 32'd0);
    end
    check("post_kill_pc", out_pc, 32'h20);

    // Reallocate tid1, then sleep/wake tid0.
    init_req = 1'b1;
    init_pc  = 32'h400;
    fetch_chk("w", 1'b0, 32'h0);   tick(); out_chk("w", 1'b0, 0, 32'h0);
    ack_chk("realloc", 1'b1, 1);
    init_req = 1'b0;
    fetch_chk("x", 1'b1, 32'h400); tick(); out_chk("x", 1'b1, 1, 32'h400);
    fetch_chk("y", 1'b1, 32'h24);  tick(); out_chk("y", 1'b1, 0, 32'h24);
    tctl_op  = 2'b01;
    tctl_tid = 3'd0;
    fetch_chk("z", 1'b1, 32'h404); tick(); out_chk("z", 1'b1, 1, 32'h404);
    check("sleep_mask", 32'(active_mask), 32'h03);
    tctl_op = 2'b00;
    fetch_chk("aa", 1'b0, 32'h0);  tick(); out_chk("aa", 1'b0, 0, 32'h0);
    fetch_chk("ab", 1'b1, 32'h408); tick(); out_chk("ab", 1'b1, 1, 32'h408);
    tctl_op  = 2'b10;
    tctl_tid = 3'd0;
    fetch_chk("ac", 1'b0, 32'h0);  tick(); out_chk("ac", 1'b0, 0, 32'h0);
    tctl_op = 2'b00;
    fetch_chk("ad", 1'b1, 32'h28); tick(); out_chk("ad", 1'b1, 0, 32'h28);
    tctl_op  = 2'b10;
    tctl_tid = 3'd1;
    fetch_chk("ae", 1'b1, 32'h40C); tick(); out_chk("ae", 1'b1, 1, 32'h40C);
    tctl_op = 2'b00;
    fetch_chk("af", 1'b1, 32'h2C); tick(); out_chk("af", 1'b1, 0, 32'h2C);

    // Fill all threads, then allocation fails.
    init_req = 1'b1;
    init_pc  = 32'h800;
    for (int k = 2; k < 8; k++) begin
      tick();
      ack_chk("fill", 1'b1, k);
    end
    tick();
    ack_chk("full", 1'b0, 0);
    check("full_mask", 32'(active_mask), 32'hFF);
    init_req = 1'b0;
    tctl_op  = 2'b11;
    tctl_tid = 3'd3;
    tick();
    check("kill3_mask", 32'(active_mask), 32'hF7);
    tctl_op  = 2'b00;
    init_req = 1'b1;
    tick();
    ack_chk("reuse3", 1'b1, 3);
    // A kill in the same cycle does not free a thread for that init.
    tctl_op  = 2'b11;
    tctl_tid = 3'd5;
    tick();
    ack_chk("kill_same", 1'b0, 0);
    check("kill5_mask", 32'(active_mask), 32'hDF);
    tctl_op = 2'b00;
    tick();
    ack_chk("reuse5", 1'b1, 5);
    init_req = 1'b0;

    // Fresh reset: redirect beats increment, PC wraps, all-idle restart.
    rst_n = 1'b0;
    tick();
    tick();
    rst_n     = 1'b1;
    redir_en  = 1'b1;
    redir_tid = 3'd0;
    redir_pc  = 32'hFFFF_FFFC;
    fetch_chk("w0", 1'b1, 32'h0);  tick(); out_chk("w0_squash", 1'b0, 0, 32'h0);
    redir_en = 1'b0;
    fetch_chk("w1", 1'b1, 32'hFFFF_FFFC); tick(); out_chk("w1", 1'b1, 0, 32'hFFFF_FFFC);
    fetch_chk("w2", 1'b0, 32'h0);  tick();
    fetch_chk("wrap", 1'b1, 32'h0); tick(); out_chk("wrap", 1'b1, 0, 32'h0);
    tctl_op  = 2'b11;
    tctl_tid = 3'd0;
    tick();
    check("idle_mask", 32'(active_mask), 32'h00);
    tctl_op = 2'b00;
    for (int s = 0; s < 3; s++) begin
      fetch_chk("idle", 1'b0, 32'h0);
      tick();
    end
    init_req = 1'b1;
    init_pc  = 32'h80;
    tick();
    ack_chk("restart", 1'b1, 0);
    init_req = 1'b0;
    fetch_chk("restart", 1'b1, 32'h80);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
